hpdmc_wrpath32: RTL and testbench

HPDMC_WRPATH32 -- requirements
Module: hpdmc_wrpath32

---
 rtl/hpdmc_wrpath32.sv | 78 +++++++
 tb/tb_hpdmc_wrpath32.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdmc_wrpath32.sv
// hpdmc_wrpath32: DDR write path sequencing DQS preamble/data/postamble and ODDR2 data/mask
module hpdmc_wrpath32 #(
  parameter int WL = 2
) (
  input  logic        sys_clk,
  input  logic        sdram_rst,
  input  logic        write_start,
  input  logic [63:0] fml_dw,
  input  logic [7:0]  fml_sel,
  output logic        dw_ack,
  output logic [31:0] dq_d0,
  output logic [31:0] dq_d1,
  output logic [3:0]  dm_d0,
  output logic [3:0]  dm_d1,
  output logic        dqs_d0,
  output logic        dqs_d1,
  output logic        dq_oe,
  output logic        dqs_oe,
  output logic        busy,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, WAIT, PRE, DATA, POST} state_t;
  localparam logic [3:0] wl_m1 = 4'(WL - 1);
  state_t state, state_nx;
  logic [3:0] wait_cnt;
  logic [1:0] beat;
  logic accept;
  assign accept = (state == IDLE) && write_start;
  // state, counters and the ignored-command error flag
  always_ff @(posedge sys_clk) begin
    if (sdram_rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      beat     <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= accept ? wl_m1 : wait_cnt - 4'(wait_cnt != 4'd0);
      beat     <= (state == DATA) ? beat + 2'd1 : 2'd0;
      err      <= write_start && (state != IDLE);
    end
  end
  // burst sequencing; WAIT is skipped entirely when the wait count starts at zero
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = write_start ? ((wl_m1 == 4'd0) ? PRE : WAIT) : IDLE;
      WAIT:    state_nx = (wait_cnt <= 4'd1) ? PRE : WAIT;
      PRE:     state_nx = DATA;
      DATA:    state_nx = (beat == 2'd3) ? POST : DATA;
      POST:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // drive enables and DQS pattern decoded from state
  always_comb begin
    dw_ack = (state == PRE) || ((state == DATA) && (beat != 2'd3));
    dq_oe  = state == DATA;
    dqs_oe = (state == PRE) || (state == DATA) || (state == POST);
    dqs_d0 = state == DATA;
    dqs_d1 = 1'b0;
    busy   = state != IDLE;
  end
  // capture each acked beat one cycle ahead of its DDR slot; masks are inverted byte enables
  always_ff @(posedge sys_clk) begin
    if (sdram_rst) begin
      dq_d0 <= '0;
      dq_d1 <= '0;
      dm_d0 <= '0;
      dm_d1 <= '0;
    end else if (dw_ack) begin
      dq_d0 <= fml_dw[63:32];
      dq_d1 <= fml_dw[31:0];
      dm_d0 <= ~fml_sel[7:4];
      dm_d1 <= ~fml_sel[3:0];
    end
  end
endmodule

// File: tb/tb_hpdmc_wrpath32.sv
// tb_hpdmc_wrpath32: directed checks of the write path for WL=2 and WL=1 builds
module tb_hpdmc_wrpath32;
  logic clk = 1'b0;
  logic rst, ws, ws1;
  logic [63:0] dw;
  logic [7:0] sel;
  logic ack, s0, s1, oe, soe, busy, err;
  logic [31:0] d0, d1;
  logic [3:0] m0, m1;
  logic ack1, s01, s11, oe1, soe1, busy1, err1;
  logic [31:0] d01, d11;
  logic [3:0] m01, m11;
  int checks = 0;
  int failures = 0;
  logic [63:0] beats [4];

  always #5 clk = ~clk;

  hpdmc_wrpath32 #(.WL(2)) u2 (
    .sys_clk(clk), .sdram_rst(rst), .write_start(ws), .fml_dw(dw), .fml_sel(sel),
    .dw_ack(ack), .dq_d0(d0), .dq_d1(d1), .dm_d0(m0), .dm_d1(m1),
    .dqs_d0(s0), .dqs_d1(s1), .dq_oe(oe), .dqs_oe(soe), .busy(busy), .err(err)
  );

  hpdmc_wrpath32 #(.WL(1)) u1 (
    .sys_clk(clk), .sdram_rst(rst), .write_start(ws1), .fml_dw(dw), .fml_sel(sel),
    .dw_ack(ack1), .dq_d0(d01), .dq_d1(d11), .dm_d0(m01), .dm_d1(m11),
    .dqs_d0(s01), .dqs_d1(s11), .dq_oe(oe1), .dqs_oe(soe1), .busy(busy1), .err(err1)
  );

  // expected {ack, dq_oe, dqs_oe, dqs_d0, dqs_d1, busy, err} r cycles after an accepted start
  function automatic logic [6:0] ctl(int r, int wl);
    return {r >= wl && r <= wl + 3, r >= wl + 1 && r <= wl + 4, r >= wl && r <= wl + 5,
            r >= wl + 1 && r <= wl + 4, 1'b0, r >= 1 && r <= wl + 5, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; ws = 1'b0; ws1 = 1'b0; dw = '0; sel = 8'hFF;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ws = 1'b1; ws1 = 1'b1; dw = 64'hFFFF_FFFF_FFFF_FFFF; sel = 8'h00;
    step();
    checks++;
    if ({ack, oe, soe, s0, s1, busy, err, d0, d1, m0, m1} !== '0) begin
      failures++;
      $display("FAIL reset_wl2 got=%h exp=0", {ack, oe, soe, s0, s1, busy, err, d0, d1, m0, m1});
    end
    checks++;
    if ({ack1, oe1, soe1, s01, s11, busy1, err1, d01, d11, m01, m11} !== '0) begin
      failures++;
      $display("FAIL reset_wl1 got=%h exp=0", {ack1, oe1, soe1, s01, s11, busy1, err1, d01, d11, m01, m11});
    end
    rst = 1'b0; ws = 1'b0; ws1 = 1'b0;
    step();
    checks++;
    if ({busy, err, busy1, err1} !== 4'b0) begin
      failures++;
      $display("FAIL reset_priority got=%b exp=0000", {busy, err, busy1, err1});
    end
  endtask

  task automatic test_single();
    logic [31:0] e0, e1;
    apply_reset();
    e0 = '0; e1 = '0;
    for (int c = 0; c < 10; c++) begin
      ws = (c == 0); sel = 8'hFF;
      dw = (c >= 2 && c <= 5) ? beats[c - 2] : 64'hBAD0_BAD0_BAD0_BAD0;
      if (c >= 3 && c <= 6) begin e0 = beats[c - 3][63:32]; e1 = beats[c - 3][31:0]; end
      checks++;
      if ({ack, oe, soe, s0, s1, busy, err} !== ctl(c, 2)) begin
        failures++;
        $display("FAIL single_ctl c=%0d got=%b exp=%b", c, {ack, oe, soe, s0, s1, busy, err}, ctl(c, 2));
      end
      checks++;
      if ({d0, d1, m0, m1} !== {e0, e1, 8'h00}) begin
        failures++;
        $display("FAIL single_data c=%0d got=%h exp=%h", c, {d0, d1, m0, m1}, {e0, e1, 8'h00});
      end
      step();
    end
  endtask

  task automatic test_mask();
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      ws = (c == 0); dw = beats[c % 4];
      sel = (c == 2) ? 8'h0F : (c == 3) ? 8'hA5 : 8'hFF;
      if (c == 3) begin
        checks++;
        if ({m0, m1} !== 8'hF0) begin
          failures++;
          $display("FAIL mask_beat0 got=%h exp=f0", {m0, m1});
        end
      end
      if (c == 4) begin
        checks++;
        if ({m0, m1} !== 8'h5A) begin
          failures++;
          $display("FAIL mask_beat1 got=%h exp=5a", {m0, m1});
        end
      end
      step();
    end
  endtask

  task automatic test_ignored();
    logic [31:0] e0, e1;
    int acks;
    apply_reset();
    e0 = '0; e1 = '0; acks = 0;
    for (int c = 0; c < 10; c++) begin
      ws = (c == 0 || c == 4); sel = 8'hFF;
      dw = (c >= 2 && c <= 5) ? beats[c - 2] : 64'hBAD1_BAD1_BAD1_BAD1;
      if (c >= 3 && c <= 6) begin e0 = beats[c - 3][63:32]; e1 = beats[c - 3][31:0]; end
      acks += int'(ack);
      checks++;
      if ({ack, oe, soe, s0, s1, busy, err} !== (ctl(c, 2) | 7'(c == 5))) begin
        failures++;
        $display("FAIL ignored_ctl c=%0d got=%b exp=%b", c, {ack, oe, soe, s0, s1, busy, err}, ctl(c, 2) | 7'(c == 5));
      end
      checks++;
      if ({d0, d1} !== {e0, e1}) begin
        failures++;
        $display("FAIL ignored_data c=%0d got=%h exp=%h", c, {d0, d1}, {e0, e1});
      end
      step();
    end
    checks++;
    if (acks != 4) begin
      failures++;
      $display("FAIL ignored_acks got=%0d exp=4", acks);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e0, e1;
    int acks;
    apply_reset();
    e0 = '0; e1 = '0; acks = 0;
    for (int c = 0; c < 18; c++) begin
      ws = (c == 0 || c == 8); sel = 8'hFF;
      dw = (c >= 2 && c <= 5) ? beats[c - 2] : (c >= 10 && c <= 13) ? ~beats[c - 10] : 64'hBAD2_BAD2_BAD2_BAD2;
      if (c >= 3 && c <= 6) begin e0 = beats[c - 3][63:32]; e1 = beats[c - 3][31:0]; end
      if (c >= 11 && c <= 14) begin e0 = ~beats[c - 11][63:32]; e1 = ~beats[c - 11][31:0]; end
      acks += int'(ack);
      checks++;
      if ({ack, oe, soe, s0, s1, busy, err} !== (c < 8 ? ctl(c, 2) : ctl(c - 8, 2))) begin
        failures++;
        $display("FAIL b2b_ctl c=%0d got=%b exp=%b", c, {ack, oe, soe, s0, s1, busy, err}, c < 8 ? ctl(c, 2) : ctl(c - 8, 2));
      end
      checks++;
      if ({d0, d1} !== {e0, e1}) begin
        failures++;
        $display("FAIL b2b_data c=%0d got=%h exp=%h", c, {d0, d1}, {e0, e1});
      end
      step();
    end
    checks++;
    if (acks != 8) begin
      failures++;
      $display("FAIL b2b_acks got=%0d exp=8", acks);
    end
  endtask

  task automatic test_wl1();
    logic [31:0] e0, e1;
    apply_reset();
    e0 = '0; e1 = '0;
    for (int c = 0; c < 9; c++) begin
      ws1 = (c == 0); sel = 8'hFF;
      dw = (c >= 1 && c <= 4) ? beats[c - 1] : 64'hBAD3_BAD3_BAD3_BAD3;
      if (c >= 2 && c <= 5) begin e0 = beats[c - 2][63:32]; e1 = beats[c - 2][31:0]; end
      checks++;
      if ({ack1, oe1, soe1, s01, s11, busy1, err1} !== ctl(c, 1)) begin
        failures++;
        $display("FAIL wl1_ctl c=%0d got=%b exp=%b", c, {ack1, oe1, soe1, s01, s11, busy1, err1}, ctl(c, 1));
      end
      checks++;
      if ({d01, d11, m01, m11} !== {e0, e1, 8'h00}) begin
        failures++;
        $display("FAIL wl1_data c=%0d got=%h exp=%h", c, {d01, d11, m01, m11}, {e0, e1, 8'h00});
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e0, e1;
    logic [6:0] ec;
    apply_reset();
    e0 = '0; e1 = '0;
    for (int c = 0; c < 15; c++) begin
      rst = (c == 4); ws = (c == 0 || c == 6); sel = 8'hFF;
      dw = (c >= 2 && c <= 4) ? beats[c - 2] : (c >= 8 && c <= 11) ? ~beats[c - 8] : 64'hBAD4_BAD4_BAD4_BAD4;
      if (c >= 3 && c <= 4) begin e0 = beats[c - 3][63:32]; e1 = beats[c - 3][31:0]; end
      if (c == 5) begin e0 = '0; e1 = '0; end
      if (c >= 9 && c <= 12) begin e0 = ~beats[c - 9][63:32]; e1 = ~beats[c - 9][31:0]; end
      ec = (c <= 4) ? ctl(c, 2) : (c == 5) ? 7'd0 : ctl(c - 6, 2);
      checks++;
      if ({ack, oe, soe, s0, s1, busy, err} !== ec) begin
        failures++;
        $display("FAIL rstmid_ctl c=%0d got=%b exp=%b", c, {ack, oe, soe, s0, s1, busy, err}, ec);
      end
      checks++;
      if ({d0, d1, m0, m1} !== {e0, e1, 8'h00}) begin
        failures++;
        $display("FAIL rstmid_data c=%0d got=%h exp=%h", c, {d0, d1, m0, m1}, {e0, e1, 8'h00});
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    beats[0] = 64'h11112222_33334444;
    beats[1] = 64'h55556666_77778888;
    beats[2] = 64'h9999AAAA_BBBBCCCC;
    beats[3] = 64'hDDDDEEEE_FFFF0000;
    rst = 1'b0; ws = 1'b0; ws1 = 1'b0; dw = '0; sel = '0;
    #1;
    test_reset();
    test_single();
    test_mask();
    test_ignored();
    test_back_to_back();
    test_wl1();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
